mem_rgb_sink: RTL and testbench
===============================

Name: mem_rgb_sink

Overview:
Capture-side counterpart of the RGB source memory. Accepts the decompressed R/G/B pixel stream from the image compression IP one pixel per enabled cycle. Writes the pixels into three word memories in raster order, counts them against the frame size, and flags 8x8-block (64-pixel) and frame completion. Has an independent read-back port so the bench or a later stage can fetch the reconstructed image.

Parameters:
DATA_W, 32, width of each colour component word
ADDR_W, 20, memory address width; depth = 2**ADDR_W words per colour (1048576)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: latch size_x/size_y, arm capture
size_x  in  32  frame width in pixels, sampled on start
size_y  in  32  frame height in pixels, sampled on start
en_write  in  1  R_I/G_I/B_I valid this cycle
R_I  in  DATA_W  red component
G_I  in  DATA_W  green component
B_I  in  DATA_W  blue component
rd_en  in  1  read request
rd_addr  in  ADDR_W  read address (pixel index)
R_RD  out  DATA_W  read-back red
G_RD  out  DATA_W  read-back green
B_RD  out  DATA_W  read-back blue
rd_valid  out  1  R_RD/G_RD/B_RD valid
finish_64  out  1  one-cycle pulse per completed 64-pixel group
finish  out  1  frame complete (level)
overflow  out  1  sticky: write attempted outside capture, or bad size
pix_count  out  32  pixels written in current frame

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, pix_count=0, finish=0, finish_64=0, overflow=0, rd_valid=0, R_RD/G_RD/B_RD=0. Memory contents are not cleared.
- States: IDLE, CAPTURE, DONE.
- start in any state: total = low 32 bits of size_x*size_y; pix_count=0; finish=0; overflow cleared.
  - total==0 or total > 2**ADDR_W: go to IDLE, set overflow.
  - Otherwise go to CAPTURE.
- start has priority over a same-cycle en_write; that write is dropped.
- CAPTURE, en_write=1: mem_{R,G,B}[pix_count] <= R_I/G_I/B_I; pix_count increments.
  - finish_64 pulses in the cycle after the write that makes pix_count a nonzero multiple of 64.
  - When the write makes pix_count==total: next state DONE, finish=1 in the following cycle.
  - If that same write also completes a 64 group, finish_64 and finish rise together.
- CAPTURE, en_write=0: hold; no timeout.
- IDLE or DONE, en_write=1: no memory write, pix_count holds, overflow set (sticky until start/rst).
- DONE: finish holds 1 until start or rst.
- Read port, usable in any state:
  - rd_en=1 at posedge N gives R_RD/G_RD/B_RD = mem[rd_addr] and rd_valid=1 after posedge N+1 (1-cycle latency).
  - rd_en=0: rd_valid=0, data outputs hold.
  - Read and write to the same address in the same cycle return the old data (read-before-write).
- Reset mid-capture: returns to IDLE; partially written data stays in memory; a new start is required.
- pix_count never wraps: capture stops at total ≤ 2**ADDR_W.

Optional Feature:
DUMP_FILE_EN: when defined, each accepted write also appends the component as "%h\n" to write_R.v/write_G.v/write_B.v, using the same line format as the source input files. Files are opened in an initial block and flushed/closed at the cycle finish rises. Without the macro, no file I/O and the block is synthesizable.

Decomposition:
- Package mem_rgb_pkg: state enum (IDLE/CAPTURE/DONE), BLOCK_PIX=64 constant, default DATA_W/ADDR_W.
- One sub-module: rgb_word_ram (single write port, registered read port, read-before-write), instantiated three times, once per colour.
- Sequencing FSM and counters stay in the top.

Test Plan:
- 8x8 frame: start with size_x=8, size_y=8; 64 writes, pixel i = {i,i+1,i+2} -> finish_64 and finish rise together one cycle after the 64th write; pix_count=64; read-back of addr 0..63 matches.
- 16x8 frame with gaps in en_write -> finish_64 at pix_count 64 and at 128; finish only at 128; data correct despite gaps.
- start with size_x=0 -> overflow=1, state IDLE; following en_write writes nothing (read addr 0 still shows old value).
- Write in DONE after an 8x8 frame -> overflow=1, pix_count stays 64, mem[64] unchanged.
- rst asserted after 30 writes -> all outputs 0 next cycle; restart with 8x8 and 64 writes -> finish=1, pix_count=64.
- Same-cycle rd_en and write to addr 5 -> R_RD returns the previous mem[5]; a re-read the next cycle returns the new value.

Source files
------------

// File: rtl/mem_rgb_sink_pkg.sv
// Shared types and constants for the RGB capture sink.
// Defines the sequencing states, the 64-pixel block size and default widths.
package mem_rgb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int BLOCK_PIX  = 64;
   localparam int BLK_BITS   = $clog2(BLOCK_PIX);
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 20;

endpackage

// File: rtl/mem_rgb_sink_ram.sv
// One colour plane: single write port plus a registered read port.
// A same-cycle read and write to one address returns the previous contents.
module rgb_word_ram
   import mem_rgb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [DATA_W-1:0] r_rdata;

   // Storage is never cleared so a partial frame survives a reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_rgb_sink.sv
// Capture sink for the decompressed RGB pixel stream with a read-back port.
//
// state   | meaning
// IDLE    | not armed; writes are rejected and flag overflow
// CAPTURE | accepting pixels into pix_count until the frame total is reached
// DONE    | frame complete, finish held high; writes flag overflow
module mem_rgb_sink
   import mem_rgb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       size_x,
   input  logic [31:0]       size_y,
   input  logic              en_write,
   input  logic [DATA_W-1:0] R_I,
   input  logic [DATA_W-1:0] G_I,
   input  logic [DATA_W-1:0] B_I,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] R_RD,
   output logic [DATA_W-1:0] G_RD,
   output logic [DATA_W-1:0] B_RD,
   output logic              rd_valid,
   output logic              finish_64,
   output logic              finish,
   output logic              overflow,
   output logic [31:0]       pix_count
);

   localparam logic [32:0] MAX_PIX = 33'd1 << ADDR_W;

   state_t      r_state;
   logic [31:0] r_total;
   logic [31:0] r_pix_count;
   logic        r_finish;
   logic        r_finish_64;
   logic        r_overflow;
   logic        r_rd_valid;

   logic [31:0]       w_total;
   logic              w_size_bad;
   logic [31:0]       w_pix_next;
   logic              w_block_done;
   logic              w_last;
   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;

   // Frame size is the low 32 bits of the product; a wrapped product of 0 is rejected.
   assign w_total      = size_x * size_y;
   assign w_size_bad   = (w_total == 32'd0) || ({1'b0, w_total} > MAX_PIX);
   assign w_pix_next   = r_pix_count + 32'd1;
   assign w_block_done = (w_pix_next[BLK_BITS-1:0] == '0);
   assign w_last       = (w_pix_next == r_total);
   assign w_we         = !rst && !start && en_write && (r_state == CAPTURE);
   assign w_waddr      = r_pix_count[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_total     <= '0;
         r_pix_count <= '0;
         r_finish    <= 1'b0;
         r_finish_64 <= 1'b0;
         r_overflow  <= 1'b0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_finish_64 <= 1'b0;
         r_rd_valid  <= rd_en;
         if (start) begin
            r_total     <= w_total;
            r_pix_count <= '0;
            r_finish    <= 1'b0;
            if (w_size_bad) begin
               r_state    <= IDLE;
               r_overflow <= 1'b1;
            end else begin
               r_state    <= CAPTURE;
               r_overflow <= 1'b0;
            end
         end else begin
            case (r_state)
               CAPTURE: begin
                  if (en_write) begin
                     r_pix_count <= w_pix_next;
                     if (w_block_done) begin
                        r_finish_64 <= 1'b1;
                     end
                     if (w_last) begin
                        r_state  <= DONE;
                        r_finish <= 1'b1;
                     end
                  end
               end
               default: begin
                  if (en_write) begin
                     r_overflow <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   rgb_word_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_r (
      .clk     (clk),
      .i_rst   (rst),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (R_I),
      .i_re    (rd_en),
      .i_raddr (rd_addr),
      .o_rdata (R_RD)
   );

   rgb_word_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_g (
      .clk     (clk),
      .i_rst   (rst),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (G_I),
      .i_re    (rd_en),
      .i_raddr (rd_addr),
      .o_rdata (G_RD)
   );

   rgb_word_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram_b (
      .clk     (clk),
      .i_rst   (rst),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (B_I),
      .i_re    (rd_en),
      .i_raddr (rd_addr),
      .o_rdata (B_RD)
   );

   assign rd_valid  = r_rd_valid;
   assign finish_64 = r_finish_64;
   assign finish    = r_finish;
   assign overflow  = r_overflow;
   assign pix_count = r_pix_count;

endmodule

// File: tb/tb_mem_rgb_sink.sv
// Bench for mem_rgb_sink: table of frame scenarios, cycle model and read scoreboard.
module tb_mem_rgb_sink;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] size_x;
   logic [31:0] size_y;
   logic        en_write;
   logic [31:0] R_I, G_I, B_I;
   logic        rd_en;
   logic [19:0] rd_addr;
   logic [31:0] R_RD, G_RD, B_RD;
   logic        rd_valid;
   logic        finish_64;
   logic        finish;
   logic        overflow;
   logic [31:0] pix_count;

   always #5 clk = ~clk;

   mem_rgb_sink #(.DATA_W(32), .ADDR_W(20)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .size_x    (size_x),
      .size_y    (size_y),
      .en_write  (en_write),
      .R_I       (R_I),
      .G_I       (G_I),
      .B_I       (B_I),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .R_RD      (R_RD),
      .G_RD      (G_RD),
      .B_RD      (B_RD),
      .rd_valid  (rd_valid),
      .finish_64 (finish_64),
      .finish    (finish),
      .overflow  (overflow),
      .pix_count (pix_count)
   );

   int n_checks = 0;
   int n_err    = 0;

   // reference model: 0 idle, 1 capture, 2 done
   int          m_st    = 0;
   int unsigned m_cnt   = 0;
   int unsigned m_total = 0;
   bit          m_fin   = 0;
   bit          m_f64   = 0;
   bit          m_ovf   = 0;
   logic [31:0] m_r [int];
   logic [31:0] m_g [int];
   logic [31:0] m_b [int];

   typedef struct {
      logic [31:0] r;
      logic [31:0] g;
      logic [31:0] b;
   } pix_t;
   pix_t sb_q[$];

   typedef struct {
      logic [31:0] sx;
      logic [31:0] sy;
      int          gap;
      int          nwr;
      int          readn;
      logic [31:0] exp_pix;
      bit          exp_fin;
      bit          exp_ovf;
      int          exp_f64;
   } frame_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock: update model from driven inputs, then compare after the edge
   task automatic step();
      pix_t        p;
      bit          exp_valid;
      logic [31:0] tot;
      exp_valid = rd_en && !rst;
      if (exp_valid) begin
         p.r = m_r.exists(int'(rd_addr)) ? m_r[int'(rd_addr)] : 32'd0;
         p.g = m_g.exists(int'(rd_addr)) ? m_g[int'(rd_addr)] : 32'd0;
         p.b = m_b.exists(int'(rd_addr)) ? m_b[int'(rd_addr)] : 32'd0;
         sb_q.push_back(p);
      end
      m_f64 = 0;
      if (rst) begin
         m_st = 0; m_cnt = 0; m_fin = 0; m_ovf = 0;
         sb_q.delete();
      end else if (start) begin
         tot   = size_x * size_y;
         m_cnt = 0;
         m_fin = 0;
         if (tot == 32'd0 || {1'b0, tot} > 33'h10_0000) begin
            m_st  = 0;
            m_ovf = 1;
         end else begin
            m_st    = 1;
            m_ovf   = 0;
            m_total = tot;
         end
      end else if (en_write) begin
         if (m_st == 1) begin
            m_r[int'(m_cnt)] = R_I;
            m_g[int'(m_cnt)] = G_I;
            m_b[int'(m_cnt)] = B_I;
            m_cnt++;
            if (m_cnt % 64 == 0) m_f64 = 1;
            if (m_cnt == m_total) begin
               m_st  = 2;
               m_fin = 1;
            end
         end else begin
            m_ovf = 1;
         end
      end
      @(posedge clk);
      #1;
      chk("pix_count", pix_count, m_cnt);
      chk("finish", finish, m_fin);
      chk("finish_64", finish_64, m_f64);
      chk("overflow", overflow, m_ovf);
      chk("rd_valid", rd_valid, exp_valid);
      if (rst) begin
         chk("rst_R_RD", R_RD, 0);
         chk("rst_G_RD", G_RD, 0);
         chk("rst_B_RD", B_RD, 0);
      end else if (rd_valid) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_read", 1, 0);
         end else begin
            p = sb_q.pop_front();
            chk("rd_R", R_RD, p.r);
            chk("rd_G", G_RD, p.g);
            chk("rd_B", B_RD, p.b);
         end
      end
   endtask

   task automatic wr(input logic [31:0] r);
      en_write = 1'b1;
      R_I = r; G_I = r + 32'd1; B_I = r + 32'd2;
      step();
      en_write = 1'b0;
   endtask

   task automatic run_frame(input frame_t f, input logic [31:0] seed);
      int f64_seen = 0;
      start = 1'b1; size_x = f.sx; size_y = f.sy;
      step();
      start = 1'b0;
      for (int i = 0; i < f.nwr; i++) begin
         if (f.gap != 0 && (i % f.gap) == 2) begin
            step();
            f64_seen += int'(finish_64);
         end
         wr(seed * 32'h1_0000 + 32'(i));
         f64_seen += int'(finish_64);
      end
      step();
      f64_seen += int'(finish_64);
      chk("frame_pix", pix_count, f.exp_pix);
      chk("frame_finish", finish, f.exp_fin);
      chk("frame_overflow", overflow, f.exp_ovf);
      chk("frame_f64_pulses", f64_seen, f.exp_f64);
      for (int a = 0; a < f.readn; a++) begin
         rd_en = 1'b1; rd_addr = 20'(a);
         step();
      end
      rd_en = 1'b0;
      step();
   endtask

   frame_t tbl [8];
   frame_t fr;

   initial begin
      tbl[0] = '{32'd8,     32'd8,     0, 64,  64,  32'd64,  1'b1, 1'b0, 1};
      tbl[1] = '{32'd16,    32'd8,     3, 128, 128, 32'd128, 1'b1, 1'b0, 2};
      tbl[2] = '{32'd0,     32'd8,     0, 2,   1,   32'd0,   1'b0, 1'b1, 0};
      tbl[3] = '{32'd8,     32'd8,     0, 65,  65,  32'd64,  1'b1, 1'b1, 1};
      tbl[4] = '{32'd1024,  32'd1024,  0, 100, 0,   32'd100, 1'b0, 1'b0, 1};
      tbl[5] = '{32'd1024,  32'd1025,  0, 0,   0,   32'd0,   1'b0, 1'b1, 0};
      tbl[6] = '{32'd65536, 32'd65536, 0, 1,   0,   32'd0,   1'b0, 1'b1, 0};
      tbl[7] = '{32'd3,     32'd5,     0, 15,  3,   32'd15,  1'b1, 1'b0, 0};

      rst = 1'b1; start = 1'b0; size_x = '0; size_y = '0; en_write = 1'b0;
      R_I = '0; G_I = '0; B_I = '0; rd_en = 1'b0; rd_addr = '0;
      step();
      step();
      rst = 1'b0;
      step();

      for (int k = 0; k < 8; k++) begin
         run_frame(tbl[k], 32'(k));
      end

      // reset in the middle of a capture, then a fresh 8x8 frame
      start = 1'b1; size_x = 32'd8; size_y = 32'd8;
      step();
      start = 1'b0;
      for (int i = 0; i < 30; i++) wr(32'h8_0000 + 32'(i));
      rd_en = 1'b1; rd_addr = 20'd3;
      step();
      rd_en = 1'b0;
      chk("pre_rst_R_RD", R_RD, 32'h0008_0003);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_pix_count", pix_count, 0);
      chk("rst_R_RD_zero", R_RD, 0);
      fr = '{32'd8, 32'd8, 0, 64, 0, 32'd64, 1'b1, 1'b0, 1};
      run_frame(fr, 32'd9);

      // start beats a same-cycle write; then read-before-write at address 5
      start = 1'b1; size_x = 32'd8; size_y = 32'd8;
      en_write = 1'b1; R_I = 32'hBAD; G_I = 32'hBAE; B_I = 32'hBAF;
      step();
      start = 1'b0; en_write = 1'b0;
      chk("start_drops_write", pix_count, 0);
      for (int i = 0; i < 5; i++) wr(32'h500 + 32'(i));
      rd_en = 1'b1; rd_addr = 20'd5;
      wr(32'h505);
      chk("rbw_old_R", R_RD, 32'h0009_0005);
      step();
      rd_en = 1'b0;
      chk("rbw_new_R", R_RD, 32'h505);
      chk("rbw_new_B", B_RD, 32'h507);
      rd_addr = 20'd0; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("start_write_not_stored", R_RD, 32'h500);
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
